// File: rtl/smg_pkg.sv
// Shared constants and helpers for the seven-segment capture monitor.
package smg_pkg;

  localparam int unsigned NDIG  = 6;
  localparam int unsigned SEGW  = 7;
  localparam int unsigned NIBW  = 4;
  localparam int unsigned DATAW = NDIG * NIBW;

  localparam logic [NDIG-1:0] SEL_IDLE = 6'h3F;
  localparam logic [SEGW-1:0] SEG_IDLE = 7'h7F;

  // Active-low segment patterns, bits 6..0 = g..a
  localparam logic [SEGW-1:0] GLYPH_0 = 7'h40;
  localparam logic [SEGW-1:0] GLYPH_1 = 7'h79;
  localparam logic [SEGW-1:0] GLYPH_2 = 7'h24;
  localparam logic [SEGW-1:0] GLYPH_3 = 7'h30;
  localparam logic [SEGW-1:0] GLYPH_4 = 7'h19;
  localparam logic [SEGW-1:0] GLYPH_5 = 7'h12;
  localparam logic [SEGW-1:0] GLYPH_6 = 7'h02;
  localparam logic [SEGW-1:0] GLYPH_7 = 7'h78;
  localparam logic [SEGW-1:0] GLYPH_8 = 7'h00;
  localparam logic [SEGW-1:0] GLYPH_9 = 7'h10;
  localparam logic [SEGW-1:0] GLYPH_A = 7'h08;
  localparam logic [SEGW-1:0] GLYPH_B = 7'h03;
  localparam logic [SEGW-1:0] GLYPH_C = 7'h46;
  localparam logic [SEGW-1:0] GLYPH_D = 7'h21;
  localparam logic [SEGW-1:0] GLYPH_E = 7'h06;
  localparam logic [SEGW-1:0] GLYPH_F = 7'h0E;

  typedef enum logic {
    ST_SETTLE = 1'b0,
    ST_HOLD   = 1'b1
  } cap_state_e;

  // True when exactly one active-low select line is asserted
  function automatic logic sel_valid(input logic [NDIG-1:0] sel);
    logic [NDIG-1:0] low;
    low = ~sel;
    return (low != '0) && ((low & (low - NDIG'(1))) == '0);
  endfunction

endpackage

// File: rtl/smg_decode_immdmod.sv
// Glyph-to-nibble decoder: inverse of the seven-segment encoder.
module smg_decode_immdmod
  import smg_pkg::*;
(
  input  logic [SEGW-1:0] seg,
  output logic            valid,
  output logic [NIBW-1:0] nib
);

  // Table lookup; anything outside the sixteen glyphs is illegal
  always_comb begin
    valid = 1'b1;
    nib   = '0;
    case (seg)
      GLYPH_0: nib = 4'h0;
      GLYPH_1: nib = 4'h1;
      GLYPH_2: nib = 4'h2;
      GLYPH_3: nib = 4'h3;
      GLYPH_4: nib = 4'h4;
      GLYPH_5: nib = 4'h5;
      GLYPH_6: nib = 4'h6;
      GLYPH_7: nib = 4'h7;
      GLYPH_8: nib = 4'h8;
      GLYPH_9: nib = 4'h9;
      GLYPH_A: nib = 4'hA;
      GLYPH_B: nib = 4'hB;
      GLYPH_C: nib = 4'hC;
      GLYPH_D: nib = 4'hD;
      GLYPH_E: nib = 4'hE;
      GLYPH_F: nib = 4'hF;
      default: valid = 1'b0;
    endcase
  end

endmodule

// File: rtl/smg_capture_mod.sv
// Seven-segment scan capture: debounces each (SEL, DIG) pair, decodes it,
// and publishes a 24-bit frame once all six digits have been seen.
module smg_capture_mod
  import smg_pkg::*;
#(
  parameter int unsigned STABLE_CYC = 16,
  parameter int unsigned TIMEOUT    = 1_000_000
) (
  input  logic             CLOCK,
  input  logic             RESET,
  input  logic [7:0]       iDIG,
  input  logic [NDIG-1:0]  iSEL,
  output logic [DATAW-1:0] oData,
  output logic [NDIG-1:0]  oErr,
  output logic             oDone,
  output logic             oTimeout
);

  localparam int unsigned CNTW = 8;
  localparam int unsigned TMOW = $clog2(TIMEOUT + 1);
  localparam logic [CNTW-1:0] CNT_ACC  = CNTW'(STABLE_CYC - 1);
  localparam logic [CNTW-1:0] CNT_MAX  = '1;
  localparam logic [TMOW-1:0] TMO_LAST = TMOW'(TIMEOUT - 1);
  localparam logic [NDIG-1:0] ALL_DIG  = '1;

  logic [SEGW-1:0]  p_dig;
  logic [NDIG-1:0]  p_sel;
  logic             p_chg;
  logic [CNTW-1:0]  stab_cnt;
  cap_state_e       state;
  logic [DATAW-1:0] shadow;
  logic [NDIG-1:0]  err_shadow;
  logic [NDIG-1:0]  captured;
  logic [TMOW-1:0]  tmo_cnt;
  logic             tmo_run;

  logic             in_chg;
  logic             in_valid;
  logic             dec_valid;
  logic [NIBW-1:0]  dec_nib;
  logic             accept;
  logic             frame_done;
  logic             tmo_hit;
  logic [NDIG-1:0]  cap_base;
  logic [NDIG-1:0]  acc_bit;
  logic             tmo_start;
  logic             unused_dp;

  // Decimal point carries no data
  assign unused_dp = iDIG[7];

  smg_decode_immdmod u_decode (
    .seg   (p_dig),
    .valid (dec_valid),
    .nib   (dec_nib)
  );

  // Event decode; completion takes priority over timeout
  always_comb begin
    in_chg     = (iDIG[SEGW-1:0] != p_dig) || (iSEL != p_sel);
    in_valid   = sel_valid(iSEL);
    accept     = (state == ST_SETTLE) && sel_valid(p_sel) && (stab_cnt == CNT_ACC);
    frame_done = (captured == ALL_DIG);
    tmo_hit    = tmo_run && (tmo_cnt == TMO_LAST) && !frame_done;
    cap_base   = (frame_done || tmo_hit) ? '0 : captured;
    acc_bit    = accept ? ~p_sel : '0;
    tmo_start  = accept && (cap_base == '0);
  end

  // Input register and stability counter, updated in lockstep so the count
  // is 0 on the first cycle a new pair sits in P
  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      p_dig    <= SEG_IDLE;
      p_sel    <= SEL_IDLE;
      p_chg    <= 1'b0;
      stab_cnt <= '0;
    end else begin
      p_dig <= iDIG[SEGW-1:0];
      p_sel <= iSEL;
      p_chg <= in_chg;
      if (!in_valid || in_chg) begin
        stab_cnt <= '0;
      end else if (stab_cnt != CNT_MAX) begin
        stab_cnt <= stab_cnt + CNTW'(1);
      end
    end
  end

  // Settle/hold FSM: one capture per stable pair
  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      state <= ST_SETTLE;
    end else begin
      case (state)
        ST_SETTLE: if (accept) state <= ST_HOLD;
        ST_HOLD:   if (p_chg)  state <= ST_SETTLE;
        default:   state <= ST_SETTLE;
      endcase
    end
  end

  // Shadow frame and per-digit bookkeeping
  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      shadow     <= '0;
      err_shadow <= '0;
      captured   <= '0;
    end else begin
      captured <= cap_base | acc_bit;
      for (int i = 0; i < NDIG; i++) begin
        if (acc_bit[i]) begin
          shadow[i*NIBW +: NIBW] <= dec_valid ? dec_nib : '0;
          err_shadow[i]          <= !dec_valid;
        end
      end
    end
  end

  // Frame timeout, armed by the first capture of a frame
  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      tmo_run <= 1'b0;
      tmo_cnt <= '0;
    end else if (tmo_start) begin
      tmo_run <= 1'b1;
      tmo_cnt <= '0;
    end else if (frame_done || tmo_hit) begin
      tmo_run <= 1'b0;
    end else if (tmo_run) begin
      tmo_cnt <= tmo_cnt + TMOW'(1);
    end
  end

  // Registered frame outputs and strobes
  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      oData    <= '0;
      oErr     <= '0;
      oDone    <= 1'b0;
      oTimeout <= 1'b0;
    end else begin
      oDone    <= frame_done;
      oTimeout <= tmo_hit;
      if (frame_done) begin
        oData <= shadow;
        oErr  <= err_shadow;
      end
    end
  end

endmodule
